// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN accelerator constants, the pooling FSM state type and a
// signed max helper.
//   DW    - feature-map word width (signed 4.16 fixed point)
//   IN_W  - input map width/height; OUT_W is the pooled map width/height
//   RD_AW - layer-0 (input map) address width
//   WR_AW - layer-1 (pooled map) address width
package cnn_pkg;

  localparam int unsigned DW    = 20;
  localparam int unsigned IN_W  = 64;
  localparam int unsigned OUT_W = IN_W / 2;
  localparam int unsigned RD_AW = 12;
  localparam int unsigned WR_AW = 10;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StRd2,
    StRd3,
    StCmp,
    StWr,
    StDone
  } pool_state_e;

  // Signed maximum; on a tie either operand is the same word.
  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_layer_if.sv
// maxpool_layer_if: bundles the pooling stage's control handshake and both
// memory ports.
//   start/busy/finish         - pass control
//   crd/caddr_rd/cdata_rd     - layer-0 read port (one-cycle read latency)
//   cwr/caddr_wr/cdata_wr     - layer-1 write port
// master: the pooling stage. slave: the surrounding system / memories.
interface maxpool_layer_if;
  import cnn_pkg::*;

  logic             start;
  logic             busy;
  logic             finish;
  logic             crd;
  logic [RD_AW-1:0] caddr_rd;
  logic [DW-1:0]    cdata_rd;
  logic             cwr;
  logic [WR_AW-1:0] caddr_wr;
  logic [DW-1:0]    cdata_wr;

  modport master (
    input  start, cdata_rd,
    output busy, finish, crd, caddr_rd, cwr, caddr_wr, cdata_wr
  );

  modport slave (
    output start, cdata_rd,
    input  busy, finish, crd, caddr_rd, cwr, caddr_wr, cdata_wr
  );

endinterface

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: holds the output pixel counter k and maps (k, read phase) to the
// layer-0 read address of the corresponding 2x2 window element.
//   i_clk, i_reset - clock, synchronous active-low reset
//   i_clr          - restart k at 0 (pass start)
//   i_inc          - advance k to the next output pixel
//   i_state        - pooling FSM state; RD0..RD3 select the window element
//   o_k            - current output index (also the layer-1 write address)
//   o_last         - k is the final output pixel
//   o_caddr_rd     - read address, 0 outside the read states
module pool_addr_gen
  import cnn_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  input  pool_state_e      i_state,
  output logic [WR_AW-1:0] o_k,
  output logic             o_last,
  output logic [RD_AW-1:0] o_caddr_rd
);

  logic [WR_AW-1:0] r_k;
  logic [RD_AW-1:0] w_base;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_k <= '0;
    end else if (i_clr) begin
      r_k <= '0;
    end else if (i_inc) begin
      r_k <= r_k + 1'b1;
    end
  end

  // Window top-left is row 2*oy, col 2*ox: the low bit of each field is zero, so
  // the +1 / +64 / +65 offsets never carry.
  assign w_base = {r_k[9:5], 1'b0, r_k[4:0], 1'b0};

  always_comb begin
    o_caddr_rd = '0;
    case (i_state)
      StRd0:   o_caddr_rd = w_base;
      StRd1:   o_caddr_rd = w_base + RD_AW'(1);
      StRd2:   o_caddr_rd = w_base + RD_AW'(IN_W);
      StRd3:   o_caddr_rd = w_base + RD_AW'(IN_W + 1);
      default: o_caddr_rd = '0;
    endcase
  end

  assign o_k    = r_k;
  assign o_last = (r_k == '1);

endmodule

// File: rtl/maxpool_layer.sv
// maxpool_layer: 2x2 stride-2 max pooling of the 64x64 layer-0 map into the
// 32x32 layer-1 map, raster order, six cycles per output pixel.
//   i_clk   - clock, rising edge
//   i_reset - synchronous active-low reset
//   io_bus  - control handshake plus layer-0 read / layer-1 write ports
// All outputs are decoded from registered state only.
module maxpool_layer
  import cnn_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  maxpool_layer_if.master io_bus
);

  pool_state_e      r_state, w_state_next;
  logic [DW-1:0]    r_max, w_max_next;
  logic             w_clr, w_inc, w_last;
  logic [WR_AW-1:0] w_k;
  logic [RD_AW-1:0] w_caddr_rd;

  pool_addr_gen u_addr_gen (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_clr),
    .i_inc      (w_inc),
    .i_state    (r_state),
    .o_k        (w_k),
    .o_last     (w_last),
    .o_caddr_rd (w_caddr_rd)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_max   <= '0;
    end else begin
      r_state <= w_state_next;
      r_max   <= w_max_next;
    end
  end

  // Read data lags the address by one cycle, so RD1 captures the RD0 word and
  // CMP folds in the RD3 word.
  always_comb begin
    w_state_next = r_state;
    w_max_next   = r_max;
    w_clr        = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_state_next = StRd0;
          w_clr        = 1'b1;
        end
      end
      StRd0: w_state_next = StRd1;
      StRd1: begin
        w_state_next = StRd2;
        w_max_next   = io_bus.cdata_rd;
      end
      StRd2: begin
        w_state_next = StRd3;
        w_max_next   = smax(r_max, io_bus.cdata_rd);
      end
      StRd3: begin
        w_state_next = StCmp;
        w_max_next   = smax(r_max, io_bus.cdata_rd);
      end
      StCmp: begin
        w_state_next = StWr;
        w_max_next   = smax(r_max, io_bus.cdata_rd);
      end
      StWr: begin
        if (w_last) begin
          w_state_next = StDone;
        end else begin
          w_inc        = 1'b1;
          w_state_next = StRd0;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign io_bus.crd      = (r_state == StRd0) || (r_state == StRd1) ||
                           (r_state == StRd2) || (r_state == StRd3);
  assign io_bus.caddr_rd = w_caddr_rd;
  assign io_bus.cwr      = (r_state == StWr);
  assign io_bus.caddr_wr = (r_state == StWr) ? w_k : '0;
  assign io_bus.cdata_wr = (r_state == StWr) ? r_max : '0;
  assign io_bus.busy     = (r_state != StIdle);
  assign io_bus.finish   = (r_state == StDone);

endmodule

// File: tb/tb_maxpool_layer.sv
// tb_maxpool_layer: drives maxpool_layer against a behavioural memory and a
// window-maximum reference model; logs every read, write and finish pulse with
// its cycle index (cycle c is the one following clock edge c-1).
module tb_maxpool_layer;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maxpool_layer_if u_if ();

  maxpool_layer u_dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io_bus  (u_if)
  );

  logic [DW-1:0] mem   [4096];
  logic [DW-1:0] exp_q [1024];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_cyc_q[$], fin_q[$];
  logic [DW-1:0] wr_data_q[$];
  bit overlap_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Layer-0 memory: one-cycle read latency.
  always @(posedge clk) if (u_if.crd) u_if.cdata_rd <= mem[u_if.caddr_rd];

  always @(negedge clk) begin
    if (u_if.crd) begin
      rd_addr_q.push_back(int'(u_if.caddr_rd));
      rd_cyc_q.push_back(cyc + 1);
    end
    if (u_if.cwr) begin
      wr_addr_q.push_back(int'(u_if.caddr_wr));
      wr_data_q.push_back(u_if.cdata_wr);
      wr_cyc_q.push_back(cyc + 1);
    end
    if (u_if.finish) fin_q.push_back(cyc + 1);
    if (u_if.crd && u_if.cwr) overlap_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    fin_q.delete();
  endtask

  // Reference: each output is the signed maximum of its 2x2 window.
  function automatic void build_model();
    for (int k = 0; k < 1024; k++) begin
      int ox = k % 32;
      int oy = k / 32;
      int best;
      int v;
      best = $signed(mem[(2 * oy) * 64 + 2 * ox]);
      for (int dy = 0; dy < 2; dy++) begin
        for (int dx = 0; dx < 2; dx++) begin
          v = $signed(mem[(2 * oy + dy) * 64 + 2 * ox + dx]);
          if (v > best) best = v;
        end
      end
      exp_q[k] = best[DW-1:0];
    end
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom());
  endtask

  task automatic check_idle_outputs(input string nm);
    check_eq({nm, "_busy"}, u_if.busy, 0);
    check_eq({nm, "_crd"}, u_if.crd, 0);
    check_eq({nm, "_cwr"}, u_if.cwr, 0);
    check_eq({nm, "_finish"}, u_if.finish, 0);
    check_eq({nm, "_caddr_rd"}, u_if.caddr_rd, 0);
    check_eq({nm, "_caddr_wr"}, u_if.caddr_wr, 0);
    check_eq({nm, "_cdata_wr"}, u_if.cdata_wr, 0);
  endtask

  // Caller sits just after a falling edge: start is sampled at edge t0.
  task automatic start_pass(output int t0);
    u_if.start = 1'b1;
    t0 = cyc + 1;
  endtask

  // Returns in the cycle after the finish pulse (t0+6146 for a timely pass).
  task automatic wait_done(input int t0);
    while (fin_q.size() == 0 && (cyc + 1) < t0 + 6300) tick();
    if (fin_q.size() == 0) check_eq("finish_timeout", 0, 1);
    tick();
  endtask

  task automatic check_pass(input string nm, input int t0);
    int errs;
    errs = 0;
    check_eq({nm, "_wr_count"}, wr_addr_q.size(), 1024);
    for (int i = 0; i < wr_addr_q.size() && i < 1024; i++) begin
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp_q[i]) errs++;
    end
    check_eq({nm, "_wr_errs"}, errs, 0);
    errs = 0;
    check_eq({nm, "_rd_count"}, rd_addr_q.size(), 4096);
    for (int i = 0; i < rd_addr_q.size() && i < 4096; i++) begin
      int k = i / 4;
      int p = i % 4;
      int a = (2 * (k / 32) + p / 2) * 64 + 2 * (k % 32) + p % 2;
      if (rd_addr_q[i] != a) errs++;
    end
    check_eq({nm, "_rd_errs"}, errs, 0);
    if (rd_cyc_q.size() > 0) check_eq({nm, "_first_rd_cyc"}, rd_cyc_q[0], t0 + 1);
    if (wr_cyc_q.size() > 0) begin
      check_eq({nm, "_first_wr_cyc"}, wr_cyc_q[0], t0 + 6);
      check_eq({nm, "_last_wr_cyc"}, wr_cyc_q[$], t0 + 6144);
    end
    check_eq({nm, "_finish_count"}, fin_q.size(), 1);
    if (fin_q.size() > 0) check_eq({nm, "_finish_cyc"}, fin_q[0], t0 + 6145);
  endtask

  initial begin
    int t0;
    int t1;
    int offs[4];
    offs = '{0, 1, 64, 65};

    rst_n = 1'b0;
    u_if.start = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    clear_log();

    // Constant map.
    for (int a = 0; a < 4096; a++) mem[a] = 20'h10000;
    build_model();
    start_pass(t0);
    tick();
    u_if.start = 1'b0;
    wait_done(t0);
    check_eq("const_idle_busy", u_if.busy, 0);
    check_pass("const", t0);
    clear_log();

    // Ramp map.
    for (int a = 0; a < 4096; a++) mem[a] = DW'(a);
    build_model();
    start_pass(t0);
    tick();
    u_if.start = 1'b0;
    wait_done(t0);
    check_pass("ramp", t0);
    if (wr_data_q.size() == 1024) begin
      check_eq("ramp_out0", wr_data_q[0], 65);
      check_eq("ramp_out31", wr_data_q[31], 127);
      check_eq("ramp_out1023", wr_data_q[1023], 4095);
    end
    if (rd_addr_q.size() >= 136) begin
      check_eq("ramp_k33_rd0", rd_addr_q[132], 130);
      check_eq("ramp_k33_rd1", rd_addr_q[133], 131);
      check_eq("ramp_k33_rd2", rd_addr_q[134], 194);
      check_eq("ramp_k33_rd3", rd_addr_q[135], 195);
    end
    clear_log();

    // Random map with planted signed and max-position windows; start pulsed in RD2.
    fill_random();
    mem[0]  = 20'hFFFFF;
    mem[1]  = 20'h80000;
    mem[64] = 20'hFFFF0;
    mem[65] = 20'h00001;
    mem[2]  = 20'hFFFFB;
    mem[3]  = 20'hFFFFD;
    mem[66] = 20'hFFFF7;
    mem[67] = 20'hFFFFD;
    for (int k = 2; k < 6; k++) begin
      for (int p = 0; p < 4; p++) mem[2 * k + offs[p]] = 20'h00100;
      mem[2 * k + offs[k - 2]] = 20'h00200;
    end
    build_model();
    start_pass(t0);
    tick();
    u_if.start = 1'b0;
    while ((cyc + 1) < t0 + 3) tick();
    check_eq("pulse_in_rd2_busy", u_if.busy, 1);
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    wait_done(t0);
    repeat (10) tick();
    check_eq("pulse_no_rerun_busy", u_if.busy, 0);
    check_pass("rand", t0);
    if (wr_data_q.size() == 1024) begin
      check_eq("signed_mix", wr_data_q[0], 20'h00001);
      check_eq("signed_allneg", wr_data_q[1], 20'hFFFFD);
      for (int k = 2; k < 6; k++) check_eq($sformatf("maxpos_%0d", k - 2), wr_data_q[k], 20'h00200);
    end
    clear_log();

    // Reset during the write of k=500.
    fill_random();
    build_model();
    start_pass(t0);
    tick();
    u_if.start = 1'b0;
    while (!(u_if.cwr && u_if.caddr_wr == 10'd500) && (cyc + 1) < t0 + 4000) tick();
    check_eq("rst_at_wr500", u_if.cwr, 1);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    check_eq("midrst_state", u_dut.r_state, StIdle);
    rst_n = 1'b1;
    clear_log();
    repeat (5) tick();
    check_eq("midrst_no_activity", wr_addr_q.size() + rd_addr_q.size(), 0);
    start_pass(t0);
    tick();
    u_if.start = 1'b0;
    wait_done(t0);
    check_pass("after_rst", t0);
    clear_log();

    // Start held through DONE: a second pass follows immediately.
    fill_random();
    build_model();
    start_pass(t0);
    wait_done(t0);
    check_eq("hold_idle_busy", u_if.busy, 0);
    check_pass("hold1", t0);
    clear_log();
    t1 = t0 + 6146;
    repeat (3) tick();
    u_if.start = 1'b0;
    wait_done(t1);
    check_pass("hold2", t1);

    check_eq("crd_cwr_exclusive", overlap_seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
